// File: rtl/regfile_sb_if.sv
// Bus bundle between the ID/WB stages and regfile_sb: read ports, writeback, issue/scoreboard and CSR access.
interface regfile_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NCSR  = 4
);
  localparam int AW = $clog2(NREGS);
  localparam int CW = (NCSR > 1) ? $clog2(NCSR) : 1;

  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      busy;
  logic                we;
  logic [AW-1:0]       wa;
  logic [XLEN-1:0]     wd;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                flush;
  logic [AW:0]         n_pending;
  logic                csr_we;
  logic [1:0]          csr_op;
  logic [CW-1:0]       csr_addr;
  logic [XLEN-1:0]     csr_wdata;
  logic [XLEN-1:0]     csr_rdata;

  modport master (
    output ra, we, wa, wd, iss_valid, iss_rd, flush, csr_we, csr_op, csr_addr, csr_wdata,
    input  rd, busy, n_pending, csr_rdata
  );

  modport slave (
    input  ra, we, wa, wd, iss_valid, iss_rd, flush, csr_we, csr_op, csr_addr, csr_wdata,
    output rd, busy, n_pending, csr_rdata
  );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with pending-write scoreboard and a small CSR bank.
// Define REGFILE_SB_FWD_EN to enable same-cycle write-through bypass on the read ports.
module regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NCSR  = 4
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam int CW = (NCSR > 1) ? $clog2(NCSR) : 1;

  logic [XLEN-1:0]  regs [NREGS];
  logic [XLEN-1:0]  csr  [NCSR];
  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pend_nx;
  logic             csr_hit;
  logic [XLEN-1:0]  csr_cur;

  function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
    logic [AW:0] cnt;
    cnt = '0;
    for (int i = 0; i < NREGS; i++) cnt = cnt + (AW+1)'(v[i]);
    return cnt;
  endfunction

  function automatic logic [XLEN-1:0] csr_apply(input logic [XLEN-1:0] cur,
                                                input logic [XLEN-1:0] opnd,
                                                input logic [1:0]      op);
    case (op)
      2'b00:   return opnd;
      2'b01:   return cur | opnd;
      2'b10:   return cur & ~opnd;
      default: return cur;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (bus.we && (bus.wa != '0)) begin
      regs[bus.wa] <= bus.wd;
    end
  end

  // Issue wins over flush, which wins over writeback: a new producer owns the register.
  always_comb begin
    pend_nx = pend;
    if (bus.we) pend_nx[bus.wa] = 1'b0;
    if (bus.flush) pend_nx = '0;
    if (bus.iss_valid && (bus.iss_rd != '0)) pend_nx[bus.iss_rd] = 1'b1;
    pend_nx[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend          <= '0;
      bus.n_pending <= '0;
    end else begin
      pend          <= pend_nx;
      bus.n_pending <= popcount(pend_nx);
    end
  end

  assign csr_hit       = (32'(bus.csr_addr) < NCSR);
  assign csr_cur       = csr_hit ? csr[bus.csr_addr] : '0;
  assign bus.csr_rdata = csr_cur;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCSR; i++) csr[i] <= '0;
    end else if (bus.csr_we && csr_hit) begin
      csr[bus.csr_addr] <= csr_apply(csr_cur, bus.csr_wdata, bus.csr_op);
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic          hit;
    assign a = bus.ra[k*AW +: AW];
`ifdef REGFILE_SB_FWD_EN
    assign hit = bus.we && (bus.wa == a) && (a != '0);
`else
    assign hit = 1'b0;
`endif
    assign bus.rd[k*XLEN +: XLEN] = (a == '0) ? '0 : (hit ? bus.wd : regs[a]);
    assign bus.busy[k]            = pend[a] & ~hit;
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed scoreboard bench for regfile_sb with three read ports.
module tb_regfile_sb;
  localparam int XLEN = 32, NREGS = 32, NRD = 3, NCSR = 4, AW = 5;
`ifdef REGFILE_SB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [31:0] v;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  sb_t  sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NCSR(NCSR)) bus ();

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NCSR(NCSR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic idle();
    bus.we = 1'b0; bus.wa = '0; bus.wd = '0;
    bus.iss_valid = 1'b0; bus.iss_rd = '0; bus.flush = 1'b0;
    bus.csr_we = 1'b0; bus.csr_op = 2'b11; bus.csr_addr = '0; bus.csr_wdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input int k, input logic [AW-1:0] a);
    bus.ra[k*AW +: AW] = a;
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    sb_q.push_back('{tag, v});
  endtask

  task automatic check(input logic [31:0] obs);
    sb_t item;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: observed %0h required an expectation", obs);
    end else begin
      item = sb_q.pop_front();
      assert (obs === item.v) else begin
        n_bad++;
        $error("FAIL %s: observed %0h expected %0h", item.tag, obs, item.v);
      end
    end
  endtask

  function automatic logic [31:0] rdk(input int k);
    return bus.rd[k*XLEN +: XLEN];
  endfunction

  task automatic write_reg(input logic [AW-1:0] a, input logic [31:0] v);
    bus.we = 1'b1; bus.wa = a; bus.wd = v;
    tick();
    idle();
  endtask

  task automatic issue(input logic [AW-1:0] a);
    bus.iss_valid = 1'b1; bus.iss_rd = a;
    tick();
    idle();
  endtask

  initial begin
    idle();
    bus.ra = '0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    // Reset state
    set_ra(0, 5'd1); set_ra(1, 5'd2); set_ra(2, 5'd31);
    push("rst_rd0", 32'h0);  check(rdk(0));
    push("rst_rd2", 32'h0);  check(rdk(2));
    push("rst_busy", 32'h0); check(32'(bus.busy));
    push("rst_npend", 32'h0); check(32'(bus.n_pending));
    push("rst_csr", 32'h0);  check(bus.csr_rdata);

    // Register 0 stays zero, even while being written
    set_ra(0, 5'd0);
    bus.we = 1'b1; bus.wa = 5'd0; bus.wd = 32'hDEADBEEF; #1;
    push("r0_during_wr", 32'h0); check(rdk(0));
    tick(); idle(); #1;
    push("r0_after_wr", 32'h0); check(rdk(0));

    // Issue then writeback of x5
    issue(5'd5);
    set_ra(0, 5'd5);
    push("iss5_busy", 32'h1);  check(32'(bus.busy[0]));
    push("iss5_npend", 32'h1); check(32'(bus.n_pending));
    bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'h12345678; #1;
    push("wb5_same_rd", FWD ? 32'h12345678 : 32'h0); check(rdk(0));
    push("wb5_same_busy", FWD ? 32'h0 : 32'h1);      check(32'(bus.busy[0]));
    tick(); idle(); #1;
    push("wb5_rd", 32'h12345678); check(rdk(0));
    push("wb5_busy", 32'h0);      check(32'(bus.busy[0]));
    push("wb5_npend", 32'h0);     check(32'(bus.n_pending));

    // Issue and writeback to x7 in the same cycle keep it pending
    issue(5'd7);
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    bus.we = 1'b1; bus.wa = 5'd7; bus.wd = 32'h000000AA;
    tick(); idle();
    set_ra(0, 5'd7);
    push("sim7_busy", 32'h1);  check(32'(bus.busy[0]));
    push("sim7_npend", 32'h1); check(32'(bus.n_pending));
    push("sim7_rd", 32'hAA);   check(rdk(0));
    write_reg(5'd7, 32'h000000AB); #1;
    push("wb7_npend", 32'h0); check(32'(bus.n_pending));

    // Writeback to a register that is not pending
    write_reg(5'd9, 32'h00000099);
    set_ra(1, 5'd9);
    push("np9_rd", 32'h99);   check(rdk(1));
    push("np9_npend", 32'h0); check(32'(bus.n_pending));

    // Flush together with an issue
    issue(5'd1); issue(5'd2); issue(5'd3); #1;
    push("pre_flush_npend", 32'h3); check(32'(bus.n_pending));
    bus.flush = 1'b1; bus.iss_valid = 1'b1; bus.iss_rd = 5'd4;
    tick(); idle();
    set_ra(0, 5'd1); set_ra(1, 5'd3); set_ra(2, 5'd4);
    push("flush_npend", 32'h1);  check(32'(bus.n_pending));
    push("flush_busy", 32'b100); check(32'(bus.busy));
    write_reg(5'd4, 32'h4); #1;
    push("wb4_npend", 32'h0); check(32'(bus.n_pending));

    // CSR write / set / clear / no-op on CSR1, read-before-write
    bus.csr_we = 1'b1; bus.csr_addr = 2'd1;
    bus.csr_op = 2'b00; bus.csr_wdata = 32'h000000F0; #1;
    push("csr_w_old", 32'h0); check(bus.csr_rdata);
    tick();
    bus.csr_op = 2'b01; bus.csr_wdata = 32'h0000000F; #1;
    push("csr_s_old", 32'hF0); check(bus.csr_rdata);
    tick();
    bus.csr_op = 2'b10; bus.csr_wdata = 32'h00000030; #1;
    push("csr_c_old", 32'hFF); check(bus.csr_rdata);
    tick();
    bus.csr_op = 2'b11; bus.csr_wdata = 32'hFFFFFFFF; #1;
    push("csr_final", 32'hCF); check(bus.csr_rdata);
    tick(); idle();
    bus.csr_addr = 2'd1; #1;
    push("csr_nop", 32'hCF); check(bus.csr_rdata);
    bus.csr_addr = 2'd2; #1;
    push("csr2_untouched", 32'h0); check(bus.csr_rdata);

    // Three independent read ports
    write_reg(5'd10, 32'h11); write_reg(5'd11, 32'h22); write_reg(5'd12, 32'h33);
    issue(5'd11);
    set_ra(0, 5'd10); set_ra(1, 5'd11); set_ra(2, 5'd12);
    push("p0_rd", 32'h11); check(rdk(0));
    push("p1_rd", 32'h22); check(rdk(1));
    push("p2_rd", 32'h33); check(rdk(2));
    push("ports_busy", 32'b010); check(32'(bus.busy));

    // Asynchronous reset in the middle of a busy cycle
    bus.we = 1'b1; bus.wa = 5'd10; bus.wd = 32'h55;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd13;
    bus.csr_we = 1'b1; bus.csr_op = 2'b00; bus.csr_addr = 2'd1; bus.csr_wdata = 32'h77;
    #2 rst = 1'b0;
    #1;
    push("arst_rd", FWD ? 32'h55 : 32'h0); check(rdk(0));
    push("arst_npend", 32'h0); check(32'(bus.n_pending));
    push("arst_csr", 32'h0);   check(bus.csr_rdata);
    tick();
    idle(); #1;
    push("arst_hold_rd1", 32'h0); check(rdk(1));
    #2 rst = 1'b1;
    write_reg(5'd10, 32'h66);
    push("post_rst_rd", 32'h66); check(rdk(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
